// File: rtl/instruction_queue.sv
// Lockstep multi-channel instruction queue: edge-triggered pushes from the HPS bus,
// registered-output pops for the video processor, with occupancy and overflow status.
module instruction_queue #(
    parameter int DATA_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int DEPTH        = 16,
    parameter int ADDR_BITS    = 4,
    parameter int AF_THRESHOLD = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                           wrreg,
    input  logic                           rdreq,
    input  logic                           clear_overflow,
    output logic [CHANNELS*DATA_WIDTH-1:0] q,
    output logic                           rdempty,
    output logic                           wrfull,
    output logic                           almost_full,
    output logic [ADDR_BITS:0]             used,
    output logic                           overflow
);

    localparam int WORD_WIDTH = CHANNELS * DATA_WIDTH;

    localparam logic [ADDR_BITS:0]   FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   AF_COUNT   = (ADDR_BITS + 1)'(AF_THRESHOLD);
    localparam logic [ADDR_BITS:0]   USED_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic                  wrreg_d;

    logic push_req;
    logic pop_req;
    logic push_ok;
    logic pop_ok;
    logic push_drop;

    // Handshake: a push is offered on each wrreg rising edge and taken unless the
    // queue is full with no simultaneous pop; a pop is offered by rdreq and taken
    // whenever the queue is non-empty, with the word appearing on q after that edge.
    always_comb begin
        push_req  = wrreg & ~wrreg_d;
        pop_req   = rdreq & ~rdempty;
        pop_ok    = pop_req;
        push_ok   = push_req & (~wrfull | pop_req);
        push_drop = push_req & wrfull & ~pop_req;
    end

    always_comb begin
        rdempty     = (used == '0);
        wrfull      = (used == FULL_COUNT);
        almost_full = (used >= AF_COUNT);
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Held high at reset so a wrreg already asserted does not look like a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrreg_d <= 1'b1;
        end else begin
            wrreg_d <= wrreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q      <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                q      <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            used <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   used <= used + USED_ONE;
                2'b01:   used <= used - USED_ONE;
                default: used <= used;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: scenario tasks drive stimulus and compare the DUT
// against a queue-based reference model of the documented accept rules.
module tb_instruction_queue;

    localparam int DW    = 32;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int AB    = 4;
    localparam int AF    = 12;
    localparam int W     = CH * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic          wrreg = 1'b0;
    logic          rdreq = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [W-1:0]  q;
    logic          rdempty;
    logic          wrfull;
    logic          almost_full;
    logic [AB:0]   used;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_qout;
    logic         m_ovf;
    logic         m_wr_prev;

    instruction_queue #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .DEPTH(DEPTH), .ADDR_BITS(AB), .AF_THRESHOLD(AF)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .wrreg(wrreg), .rdreq(rdreq),
        .clear_overflow(clear_overflow), .q(q), .rdempty(rdempty), .wrfull(wrfull),
        .almost_full(almost_full), .used(used), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom()};
    endfunction

    // One clock edge with the given inputs; model follows the queue rules.
    task automatic step(input logic wr, input logic rd, input logic clr, input logic [W-1:0] d);
        logic edge_seen;
        logic pop;
        logic drop;
        @(negedge clk);
        reset = 1'b0;
        wrreg = wr;
        rdreq = rd;
        clear_overflow = clr;
        data_in = d;
        @(posedge clk);
        edge_seen = wr && !m_wr_prev;
        m_wr_prev = wr;
        pop  = rd && (m_q.size() != 0);
        drop = edge_seen && (m_q.size() == DEPTH) && !pop;
        if (pop) m_qout = m_q.pop_front();
        if (edge_seen && !drop) m_q.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
    endtask

    task automatic do_reset(input logic wr);
        @(negedge clk);
        reset = 1'b1;
        wrreg = wr;
        rdreq = $urandom_range(0, 1);
        clear_overflow = 1'b0;
        data_in = rand_word();
        @(posedge clk);
        m_q.delete();
        m_qout = '0;
        m_ovf = 1'b0;
        m_wr_prev = 1'b1;
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic clr);
        step(1'b0, 1'b0, 1'b0, rand_word());
        step(1'b1, 1'b0, clr, d);
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        do_reset(1'b1);
        checks++; if (used !== 0) begin errors++; $display("FAIL reset_used got=%0d exp=0", used); end
        checks++; if (rdempty !== 1'b1) begin errors++; $display("FAIL reset_rdempty got=%b exp=1", rdempty); end
        checks++; if (wrfull !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%b af=%b exp=0/0", wrfull, almost_full); end
        checks++; if (q !== '0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, rand_word());
            checks++; if (used !== 0 || rdempty !== 1'b1) begin errors++; $display("FAIL held_wrreg cyc=%0d got used=%0d empty=%b exp=0/1", i, used, rdempty); end
        end
    endtask

    task automatic test_basic_order();
        logic [W-1:0] words [3];
        logic [W-1:0] exp_q [3];
        words[0] = {32'h11, 32'h22};
        words[1] = {32'h33, 32'h44};
        words[2] = {32'h55, 32'h66};
        exp_q[0] = 64'h0000001100000022;
        exp_q[1] = 64'h0000003300000044;
        exp_q[2] = 64'h0000005500000066;
        for (int i = 0; i < 3; i++) push_word(words[i], 1'b0);
        checks++; if (used !== 3) begin errors++; $display("FAIL basic_used got=%0d exp=3", used); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, rand_word());
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL basic_q idx=%0d got=%h exp=%h", i, q, exp_q[i]); end
        end
        checks++; if (rdempty !== 1'b1 || used !== 0) begin errors++; $display("FAIL basic_empty got empty=%b used=%0d exp=1/0", rdempty, used); end
        step(1'b0, 1'b1, 1'b0, rand_word());
        checks++; if (q !== exp_q[2]) begin errors++; $display("FAIL empty_read_holds got=%h exp=%h", q, exp_q[2]); end
    endtask

    task automatic test_fill_overflow();
        do_reset(1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            push_word(rand_word(), 1'b0);
            checks++;
            if (int'(used) !== k || almost_full !== (k >= AF) || wrfull !== (k == DEPTH)) begin
                errors++;
                $display("FAIL fill k=%0d got used=%0d af=%b full=%b exp used=%0d af=%b full=%b",
                         k, used, almost_full, wrfull, k, (k >= AF), (k == DEPTH));
            end
        end
        push_word(rand_word(), 1'b0);
        checks++; if (overflow !== 1'b1 || used !== 16) begin errors++; $display("FAIL drop got ovf=%b used=%0d exp=1/16", overflow, used); end
        step(1'b0, 1'b0, 1'b1, rand_word());
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got=%b exp=0", overflow); end
        push_word(rand_word(), 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b exp=1", overflow); end
        step(1'b0, 1'b0, 1'b1, rand_word());
        checks++; if (overflow !== 1'b0 || used !== 16) begin errors++; $display("FAIL clear_again got ovf=%b used=%0d exp=0/16", overflow, used); end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] oldest;
        logic [W-1:0] newest;
        oldest = m_q[0];
        newest = rand_word();
        step(1'b0, 1'b0, 1'b0, rand_word());
        step(1'b1, 1'b1, 1'b0, newest);
        checks++; if (used !== 16 || overflow !== 1'b0) begin errors++; $display("FAIL full_pp got used=%0d ovf=%b exp=16/0", used, overflow); end
        checks++; if (q !== oldest) begin errors++; $display("FAIL full_pp_q got=%h exp=%h", q, oldest); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, rand_word());
            checks++; if (q !== m_qout) begin errors++; $display("FAIL drain idx=%0d got=%h exp=%h", i, q, m_qout); end
        end
        checks++; if (q !== newest || rdempty !== 1'b1) begin errors++; $display("FAIL drain_last got q=%h empty=%b exp=%h/1", q, rdempty, newest); end
    endtask

    task automatic test_empty_push_pop();
        logic [W-1:0] held;
        logic [W-1:0] d;
        held = m_qout;
        d = rand_word();
        step(1'b0, 1'b0, 1'b0, rand_word());
        step(1'b1, 1'b1, 1'b0, d);
        checks++; if (used !== 1 || rdempty !== 1'b0) begin errors++; $display("FAIL empty_pp got used=%0d empty=%b exp=1/0", used, rdempty); end
        checks++; if (q !== held) begin errors++; $display("FAIL empty_pp_q got=%h exp=%h", q, held); end
        step(1'b0, 1'b1, 1'b0, rand_word());
        checks++; if (q !== d) begin errors++; $display("FAIL empty_pp_read got=%h exp=%h", q, d); end
    endtask

    task automatic test_wrap_random();
        logic [W-1:0] d;
        for (int i = 0; i < 40; i++) begin
            d = rand_word();
            step(1'b1, 1'b0, 1'b0, d);
            step(1'b0, 1'b1, 1'b0, rand_word());
            checks++; if (q !== d || used !== 0) begin errors++; $display("FAIL wrap i=%0d got q=%h used=%0d exp=%h/0", i, q, used, d); end
        end
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), rand_word());
            checks++;
            if (q !== m_qout || int'(used) !== m_q.size() || overflow !== m_ovf ||
                rdempty !== (m_q.size() == 0) || wrfull !== (m_q.size() == DEPTH) ||
                almost_full !== (m_q.size() >= AF)) begin
                errors++;
                $display("FAIL random cyc=%0d got q=%h used=%0d ovf=%b e/f/af=%b%b%b exp q=%h used=%0d ovf=%b",
                         i, q, used, overflow, rdempty, wrfull, almost_full, m_qout, m_q.size(), m_ovf);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) push_word(rand_word(), 1'b0);
        step(1'b0, 1'b1, 1'b0, rand_word());
        do_reset(1'b1);
        checks++; if (used !== 0 || q !== '0 || rdempty !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset got used=%0d q=%h empty=%b ovf=%b exp=0/0/1/0", used, q, rdempty, overflow);
        end
        step(1'b1, 1'b1, 1'b0, rand_word());
        checks++; if (used !== 0) begin errors++; $display("FAIL mid_reset_held got used=%0d exp=0", used); end
    endtask

    initial begin
        m_qout = '0;
        m_ovf = 1'b0;
        m_wr_prev = 1'b1;
        test_reset();
        test_basic_order();
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Parametrised successor to the two-FIFO instruction ingress path.
- Accepts a CHANNELS-wide instruction word from the HPS bus on a level write-request, converts each rising edge into exactly one push, and stores all channels in lockstep in one single-clock queue.
- The video processor drains the queue with rdreq/rdempty.
- Adds occupancy count, almost-full threshold, sticky overflow detection and a programmable clear, none of which the current path provides.

Parameters:
- DATA_WIDTH, 32: width of one channel word.
- CHANNELS, 2: number of lockstep channels (dataA, dataB, ...).
- DEPTH, 16: entries; must be a power of two, minimum 2.
- ADDR_BITS, 4: log2(DEPTH).
- AF_THRESHOLD, 12: almost_full asserts when used >= AF_THRESHOLD; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  CHANNELS*DATA_WIDTH  concatenated channel words; channel 0 occupies the LSBs.
- wrreg  in  1  level write request from HPS; a push occurs on each 0->1 transition.
- rdreq  in  1  read request from the consumer.
- clear_overflow  in  1  clears the overflow flag.
- q  out  CHANNELS*DATA_WIDTH  registered read data.
- rdempty  out  1  queue empty (used == 0).
- wrfull  out  1  queue full (used == DEPTH).
- almost_full  out  1  used >= AF_THRESHOLD.
- used  out  ADDR_BITS+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset (sync, active-high, dominates all other inputs):
  - wr_ptr = 0, rd_ptr = 0, used = 0, q = 0, overflow = 0.
  - rdempty = 1, wrfull = 0, almost_full = 0.
  - Edge-detect register resets to 1, so a wrreg held high across reset does not push.
  - Storage contents are not reset.
- Write detection:
  - push_req = wrreg & ~wrreg_d, where wrreg_d is wrreg registered.
  - A push_req produces exactly one push attempt per rising edge, regardless of how long wrreg stays high.
  - data_in is sampled in the same cycle as push_req.
- Read: pop_req = rdreq & ~rdempty. rdreq while empty is ignored; q holds.
- Accept rules, evaluated on the registered state:
  - Empty, push and pop in the same cycle: push accepted, pop ignored (rdempty=1); used becomes 1.
  - Full, push and pop in the same cycle: both accepted; used unchanged; no overflow.
  - Full, push only: push dropped; pointers and used unchanged; overflow set next cycle.
  - Otherwise: push increments used, pop decrements it, both together leave it unchanged.
- Read latency: 1 cycle. On an accepted pop at edge N, q shows the head entry after edge N, and rd_ptr increments. q holds its value at all other times (normal/legacy mode, not show-ahead).
- Pointers: ADDR_BITS wide, wrap modulo DEPTH with no special case at DEPTH-1 -> 0.
- Flags:
  - rdempty, wrfull and almost_full are combinational decodes of the registered used.
  - They change in the cycle after the push/pop that caused the change.
- Overflow:
  - Set by a dropped push; cleared by clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- Width rule: used is ADDR_BITS+1 bits so DEPTH is representable; no arithmetic saturates silently.
- Reset mid-operation: queue empties immediately after the reset edge, q = 0, any pending edge is discarded.

Test Plan:
- Reset with wrreg held 1, then release reset keeping wrreg=1 for 5 cycles -> used stays 0, rdempty=1, no push.
- wrreg pulses 0->1 three times with data_in = {B=0x11,A=0x22}, {0x33,0x44}, {0x55,0x66}, then rdreq=1 for 3 cycles -> q = 0x0000001100000022, 0x0000003300000044, 0x0000005500000066 on successive cycles, each 1 cycle after its read edge; rdempty=1 after the third read.
- Defaults: 12 pushes -> almost_full=1 with used=12. 16 pushes -> wrfull=1. 17th push -> dropped, overflow=1, used=16. clear_overflow=1 -> overflow=0.
- Full queue, push edge and rdreq in the same cycle -> used stays 16, overflow stays 0, q equals the oldest entry, the new word becomes the last entry.
- Empty queue, push edge and rdreq in the same cycle -> used=1, q unchanged; the next rdreq returns the pushed word.
- 40 push/pop pairs to exercise pointer wrap -> data order preserved across the 15->0 wrap. Reset asserted mid-stream -> used=0, q=0 on the next cycle.
